register_file: RTL and testbench

32 × 32-bit MIPS general-purpose register file for the single-cycle datapath. It sits directly downstream of the write-register select mux, which supplies `writeReg` (rt or rd). It provides two combinational read ports (rs, rt), one primary write port, and a dedicated link port through which jal writes $31. Bypass, a debug read port and a saturating write counter support the bench and the top-level monitor.

---
 rtl/register_file.sv | 112 +++++++++++
 tb/tb_register_file.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x WIDTH MIPS register file: two bypassed combinational read ports, a primary
// write port, a dedicated $31 link port, a raw debug port and a saturating write counter.

module rf_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (wr_en) data_d = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;
endmodule

module register_file #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           readReg1,
    input  logic [4:0]           readReg2,
    input  logic [4:0]           writeReg,
    input  logic [WIDTH-1:0]     writeData,
    input  logic                 regWrite,
    input  logic                 linkWrite,
    input  logic [WIDTH-1:0]     linkData,
    input  logic [4:0]           dbgReg,
    output logic [WIDTH-1:0]     readData1,
    output logic [WIDTH-1:0]     readData2,
    output logic [WIDTH-1:0]     dbgData,
    output logic [CNT_WIDTH-1:0] writeCount
);
    localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    logic [WIDTH-1:0] regs [32];
    logic             link_en;
    logic             prim_en;
    logic             prim_eff;
    logic [1:0]       n_commit;

    // Enables are masked by reset so the bypass cannot leak data while reset is held.
    assign link_en  = linkWrite & ~reset;
    assign prim_en  = regWrite & ~reset & (writeReg != 5'd0);
    // A primary write aimed at $31 loses to a simultaneous link write.
    assign prim_eff = prim_en & ~(link_en & (writeReg == 5'd31));
    assign n_commit = {1'b0, prim_eff} + {1'b0, link_en};

    assign regs[0] = '0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        logic             we;
        logic [WIDTH-1:0] wd;
        logic             link_hit;

        assign link_hit = link_en & (i == 31);
        assign we       = link_hit | (prim_eff & (writeReg == 5'(i)));
        assign wd       = link_hit ? linkData : writeData;

        rf_entry #(.WIDTH(WIDTH)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (we),
            .wr_data (wd),
            .q       (regs[i])
        );
    end

    always_comb begin
        readData1 = regs[readReg1];
        if (link_en && readReg1 == 5'd31)               readData1 = linkData;
        else if (prim_eff && readReg1 == writeReg)      readData1 = writeData;
    end

    always_comb begin
        readData2 = regs[readReg2];
        if (link_en && readReg2 == 5'd31)               readData2 = linkData;
        else if (prim_eff && readReg2 == writeReg)      readData2 = writeData;
    end

    assign dbgData = regs[dbgReg];

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic [CNT_WIDTH:0]   cnt_sum;

    // One extra bit on the sum lets a +2 from max-1 clamp instead of wrapping.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + {{(CNT_WIDTH-1){1'b0}}, n_commit};
        cnt_d   = cnt_sum[CNT_WIDTH-1:0];
        if (cnt_sum > CNT_MAX) cnt_d = CNT_MAX[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign writeCount = cnt_q;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, basic access, $0 protection, bypass,
// link priority, and counter saturation on a narrow-counter instance.

module tb_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readReg1, readReg2, writeReg, dbgReg;
    logic [31:0] writeData, linkData;
    logic        regWrite, linkWrite;
    logic [31:0] readData1, readData2, dbgData;
    logic [15:0] writeCount;

    logic [4:0]  s_readReg1, s_readReg2, s_writeReg, s_dbgReg;
    logic [31:0] s_writeData, s_linkData;
    logic        s_regWrite, s_linkWrite;
    logic [31:0] s_readData1, s_readData2, s_dbgData;
    logic [3:0]  s_writeCount;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    register_file #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .linkWrite(linkWrite), .linkData(linkData), .dbgReg(dbgReg),
        .readData1(readData1), .readData2(readData2), .dbgData(dbgData),
        .writeCount(writeCount)
    );

    register_file #(.WIDTH(32), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .readReg1(s_readReg1), .readReg2(s_readReg2),
        .writeReg(s_writeReg), .writeData(s_writeData), .regWrite(s_regWrite),
        .linkWrite(s_linkWrite), .linkData(s_linkData), .dbgReg(s_dbgReg),
        .readData1(s_readData1), .readData2(s_readData2), .dbgData(s_dbgData),
        .writeCount(s_writeCount)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite = 1'b0; linkWrite = 1'b0; writeReg = 5'd0;
        writeData = '0; linkData = '0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (readData1 !== 32'h0 || readData2 !== 32'h0 || dbgData !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs rd1=%h rd2=%h dbg=%h expected all 0", readData1, readData2, dbgData);
        end
        vectors++;
        if (writeCount !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d expected 0", writeCount);
        end
        @(negedge clk); reset = 1'b0;
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'h1234;
        cyc();
        idle(); dbgReg = 5'd5; #1;
        vectors++;
        if (dbgData !== 32'h1234) begin
            miscompares++;
            $display("FAIL preload_5 got %h expected 00001234", dbgData);
        end
        // assert reset mid-cycle with a write and bypass in flight
        #2;
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hCAFE; readReg1 = 5'd5;
        reset = 1'b1; #1;
        vectors++;
        if (dbgData !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_async_dbg got %h expected 0", dbgData);
        end
        vectors++;
        if (writeCount !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_async_count got %0d expected 0", writeCount);
        end
        vectors++;
        if (readData1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_no_bypass got %h expected 0", readData1);
        end
        cyc();
        vectors++;
        if (dbgData !== 32'h0 || writeCount !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_edge_nowrite dbg=%h cnt=%0d expected 0/0", dbgData, writeCount);
        end
        @(negedge clk); idle(); reset = 1'b0; readReg1 = 5'd0;
    endtask

    task automatic test_basic();
        regWrite = 1'b1; writeReg = 5'd8; writeData = 32'hDEADBEEF;
        cyc();
        idle(); readReg1 = 5'd8; readReg2 = 5'd0; dbgReg = 5'd8; #1;
        vectors++;
        if (readData1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_rd1 got %h expected deadbeef", readData1);
        end
        vectors++;
        if (readData2 !== 32'h0) begin
            miscompares++;
            $display("FAIL basic_rd2 got %h expected 0", readData2);
        end
        vectors++;
        if (writeCount !== 16'd1 || dbgData !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_cnt_dbg cnt=%0d dbg=%h expected 1/deadbeef", writeCount, dbgData);
        end
    endtask

    task automatic test_zero();
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF; readReg1 = 5'd0; #1;
        vectors++;
        if (readData1 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_bypass got %h expected 0", readData1);
        end
        cyc();
        idle(); dbgReg = 5'd0; #1;
        vectors++;
        if (readData1 !== 32'h0 || dbgData !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_store rd1=%h dbg=%h expected 0/0", readData1, dbgData);
        end
        vectors++;
        if (writeCount !== 16'd1) begin
            miscompares++;
            $display("FAIL zero_count got %0d expected 1", writeCount);
        end
    endtask

    task automatic test_bypass();
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h1;
        cyc();
        writeData = 32'hA5A5A5A5; readReg2 = 5'd9; readReg1 = 5'd8; dbgReg = 5'd9; #1;
        vectors++;
        if (readData2 !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL bypass_rd2 got %h expected a5a5a5a5", readData2);
        end
        vectors++;
        if (dbgData !== 32'h1) begin
            miscompares++;
            $display("FAIL bypass_dbg_raw got %h expected 00000001", dbgData);
        end
        vectors++;
        if (readData1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_other_port got %h expected deadbeef", readData1);
        end
        cyc();
        idle(); #1;
        vectors++;
        if (dbgData !== 32'hA5A5A5A5 || writeCount !== 16'd3) begin
            miscompares++;
            $display("FAIL bypass_commit dbg=%h cnt=%0d expected a5a5a5a5/3", dbgData, writeCount);
        end
    endtask

    task automatic test_link();
        regWrite = 1'b1; writeReg = 5'd31; writeData = 32'h11;
        linkWrite = 1'b1; linkData = 32'h00400008; readReg1 = 5'd31; #1;
        vectors++;
        if (readData1 !== 32'h00400008) begin
            miscompares++;
            $display("FAIL link_bypass_prio got %h expected 00400008", readData1);
        end
        cyc();
        idle(); dbgReg = 5'd31; #1;
        vectors++;
        if (dbgData !== 32'h00400008 || writeCount !== 16'd4) begin
            miscompares++;
            $display("FAIL link_prio_commit dbg=%h cnt=%0d expected 00400008/4", dbgData, writeCount);
        end
        regWrite = 1'b1; writeReg = 5'd4; writeData = 32'h44;
        linkWrite = 1'b1; linkData = 32'h0040000C; readReg1 = 5'd4; readReg2 = 5'd31; #1;
        vectors++;
        if (readData1 !== 32'h44 || readData2 !== 32'h0040000C) begin
            miscompares++;
            $display("FAIL dual_bypass rd1=%h rd2=%h expected 00000044/0040000c", readData1, readData2);
        end
        cyc();
        idle(); dbgReg = 5'd4; #1;
        vectors++;
        if (dbgData !== 32'h44 || writeCount !== 16'd6) begin
            miscompares++;
            $display("FAIL dual_commit dbg4=%h cnt=%0d expected 00000044/6", dbgData, writeCount);
        end
        dbgReg = 5'd31; #1;
        vectors++;
        if (dbgData !== 32'h0040000C) begin
            miscompares++;
            $display("FAIL dual_commit_31 got %h expected 0040000c", dbgData);
        end
    endtask

    task automatic test_saturation();
        // 6 single writes then 7 dual writes = 20 commits into a 4-bit counter
        logic [3:0] exp_cnt [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                      4'd8, 4'd10, 4'd12, 4'd14, 4'd15, 4'd15, 4'd15};
        for (int k = 0; k < 13; k++) begin
            s_regWrite  = 1'b1;
            s_writeReg  = (k < 6) ? 5'(k + 1) : 5'd2;
            s_writeData = 32'(k);
            s_linkWrite = (k >= 6);
            s_linkData  = 32'h00400000 + 32'(k);
            cyc();
            vectors++;
            if (s_writeCount !== exp_cnt[k]) begin
                miscompares++;
                $display("FAIL sat_step%0d got %0d expected %0d", k, s_writeCount, exp_cnt[k]);
            end
        end
        s_regWrite = 1'b1; s_writeReg = 5'd3; s_linkWrite = 1'b0;
        cyc();
        s_regWrite = 1'b0;
        vectors++;
        if (s_writeCount !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_hold got %0d expected 15", s_writeCount);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle(); readReg1 = '0; readReg2 = '0; dbgReg = '0;
        s_regWrite = 1'b0; s_linkWrite = 1'b0; s_writeReg = '0; s_writeData = '0;
        s_linkData = '0; s_readReg1 = '0; s_readReg2 = '0; s_dbgReg = '0;
        test_reset();
        test_basic();
        test_zero();
        test_bypass();
        test_link();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
